// File: rtl/bus030_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus030_pkg
//  Description : Shared types and constants for the 68030-style bus-cycle
//                initiator: state encoding, SIZ codes, DSACK port sizes.
//  Revision    : 1.0  initial release
// ============================================================================
package bus030_pkg;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S0    = 3'd1,
        ST_S1    = 3'd2,
        ST_S2    = 3'd3,
        ST_WAIT  = 3'd4,
        ST_LATCH = 3'd5,
        ST_S5    = 3'd6,
        ST_TERM  = 3'd7
    } state_t;

    // 68030 SIZ1:SIZ0 transfer-size encodings
    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // Responder port width as reported back to the client
    localparam logic [1:0] PORT_NONE = 2'b00;
    localparam logic [1:0] PORT_8    = 2'b01;
    localparam logic [1:0] PORT_16   = 2'b10;
    localparam logic [1:0] PORT_32   = 2'b11;

    // Map active-low {DSACK1_n, DSACK0_n} to the port width it announces
    function automatic logic [1:0] dsack_to_port(input logic [1:0] dsack_n);
        logic [1:0] port;
        case (dsack_n)
            2'b00:   port = PORT_32;
            2'b01:   port = PORT_16;
            2'b10:   port = PORT_8;
            default: port = PORT_NONE;
        endcase
        return port;
    endfunction

endpackage : bus030_pkg
`default_nettype wire

// File: rtl/bus_initiator_030_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Parameterised-width two-flop synchroniser. Resets to all
//                ones so active-low strobes come out of reset negated.
//  Revision    : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/bus_initiator_030.sv
`default_nettype none
// ============================================================================
//  Module      : bus_initiator_030
//  Description : 68030-style asynchronous bus-cycle initiator. Accepts one
//                read or write from a client, runs the AS/DS strobe sequence,
//                waits for DSACK/BERR (or a timeout) and returns a one-cycle
//                response carrying read data, error and port width.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_initiator_030
    import bus030_pkg::*;
#(
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_n,
    // client request port
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_siz,
    input  logic [DATA_W-1:0] req_wdata,
    // client response port
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [1:0]        resp_port,
    // 68030 bus
    output logic [ADDR_W-1:0] ADDR,
    output logic              RW,
    output logic              SIZ0,
    output logic              SIZ1,
    output logic              AS_n,
    output logic              DS_n,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_OE,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [1:0]        DSACK_n,
    input  logic              BERR_n
);

    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw_out;
    logic                r_is_read;
    logic [1:0]          r_siz;
    logic [DATA_W-1:0]   r_dout;
    logic                r_oe;
    logic                r_as_n;
    logic                r_ds_n;
    logic [15:0]         r_cnt;
    logic                r_err;
    logic [1:0]          r_port;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [1:0]          r_resp_port;
    logic [DATA_W-1:0]   r_rdata;

    logic [2:0]          w_sync_q;
    logic                w_sberr_n;
    logic [1:0]          w_sdsack_n;

    // Responder strobes are asynchronous; only their synchronised copies
    // are allowed to steer the sequencer.
    sync2 #(
        .WIDTH (3)
    ) u_sync (
        .CLK   (CLK),
        .RST_n (RST_n),
        .i_d   ({BERR_n, DSACK_n}),
        .o_q   (w_sync_q)
    );

    assign w_sberr_n  = w_sync_q[2];
    assign w_sdsack_n = w_sync_q[1:0];

    // Bus-cycle sequencer; every bus and response output is registered here
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_rw_out     <= 1'b1;
            r_is_read    <= 1'b1;
            r_siz        <= 2'b00;
            r_dout       <= '0;
            r_oe         <= 1'b0;
            r_as_n       <= 1'b1;
            r_ds_n       <= 1'b1;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_port       <= PORT_NONE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_port  <= PORT_NONE;
            r_rdata      <= '0;
        end else begin
            // The completion pulse is only ever raised for one cycle
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr;
                        r_rw_out  <= req_rw;
                        r_is_read <= req_rw;
                        r_siz     <= req_siz;
                        r_dout    <= req_wdata;
                        r_state   <= ST_S0;
                    end
                end
                ST_S0: begin
                    // Address has had a cycle to settle; open the cycle.
                    // Reads strobe DS with AS, writes first drive the data.
                    r_as_n <= 1'b0;
                    if (r_is_read) begin
                        r_ds_n <= 1'b0;
                    end else begin
                        r_oe <= 1'b1;
                    end
                    r_state <= ST_S1;
                end
                ST_S1: begin
                    // Write data has been on the bus a cycle; now strobe it
                    r_ds_n  <= 1'b0;
                    r_state <= ST_S2;
                end
                ST_S2: begin
                    r_cnt   <= C_TIMEOUT;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!w_sberr_n) begin
                        // Bus error takes priority over a simultaneous DSACK
                        r_err   <= 1'b1;
                        r_port  <= PORT_NONE;
                        r_state <= ST_LATCH;
                    end else if (w_sdsack_n != 2'b11) begin
                        r_err   <= 1'b0;
                        r_port  <= dsack_to_port(w_sdsack_n);
                        r_state <= ST_LATCH;
                    end else if (r_cnt == 16'd1) begin
                        // No responder claimed the cycle in time
                        r_err   <= 1'b1;
                        r_port  <= PORT_NONE;
                        r_state <= ST_LATCH;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_LATCH: begin
                    if (r_is_read && !r_err) begin
                        r_rdata <= DATA_IN;
                    end
                    r_as_n       <= 1'b1;
                    r_ds_n       <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= r_err;
                    r_resp_port  <= r_port;
                    r_state      <= ST_S5;
                end
                ST_S5: begin
                    // Write data was held through S5; release the bus now
                    r_oe     <= 1'b0;
                    r_rw_out <= 1'b1;
                    r_state  <= ST_TERM;
                end
                ST_TERM: begin
                    // Do not start another cycle until the responder lets go
                    if (w_sync_q == 3'b111) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;
    assign resp_port  = r_resp_port;
    assign ADDR       = r_addr;
    assign RW         = r_rw_out;
    assign SIZ0       = r_siz[0];
    assign SIZ1       = r_siz[1];
    assign AS_n       = r_as_n;
    assign DS_n       = r_ds_n;
    assign DATA_OUT   = r_dout;
    assign DATA_OE    = r_oe;

endmodule : bus_initiator_030
`default_nettype wire

// File: tb/tb_bus_initiator_030.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_initiator_030
//  Description : Self-checking bench for bus_initiator_030 with a cycle-level
//                responder model and a queue of expected responses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_initiator_030;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    logic              CLK = 1'b0;
    logic              RST_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_siz;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [1:0]        resp_port;
    logic [ADDR_W-1:0] ADDR;
    logic              RW;
    logic              SIZ0;
    logic              SIZ1;
    logic              AS_n;
    logic              DS_n;
    logic [DATA_W-1:0] DATA_OUT;
    logic              DATA_OE;
    logic [DATA_W-1:0] DATA_IN;
    logic [1:0]        DSACK_n;
    logic              BERR_n;

    always #5 CLK = ~CLK;

    bus_initiator_030 #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TMO)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_siz    (req_siz),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_port  (resp_port),
        .ADDR       (ADDR),
        .RW         (RW),
        .SIZ0       (SIZ0),
        .SIZ1       (SIZ1),
        .AS_n       (AS_n),
        .DS_n       (DS_n),
        .DATA_OUT   (DATA_OUT),
        .DATA_OE    (DATA_OE),
        .DATA_IN    (DATA_IN),
        .DSACK_n    (DSACK_n),
        .BERR_n     (BERR_n)
    );

    // Expected completion: cycle number (acceptance edge = 0) and fields
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  port;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] exp_rdata = 32'h0;   // resp_rdata holds the last good read

    // Observations from the most recent bus cycle
    logic        ob_got;
    logic        ob_dup;
    int          ob_resp_cyc;
    logic [31:0] ob_rdata;
    logic        ob_err;
    logic [1:0]  ob_port;
    int          ob_as_first, ob_as_last, ob_ds_first;
    int          ob_oe_first, ob_oe_last, ob_ready_first, ob_rel;
    logic [27:0] ob_addr_s0;
    logic        ob_rw_s0;
    logic [1:0]  ob_siz_s0;
    logic        ob_dout_bad;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Issue one request and play the responder: assert dsack_v/berr_v
    // dly cycles after AS_n falls, keep them until hold cycles after AS_n
    // rises. With poke set, req_valid is raised while the bus is in TERM.
    task automatic run_cycle(input logic rw, input logic [27:0] addr,
                             input logic [1:0] siz, input logic [31:0] wdata,
                             input int dly, input logic [1:0] dsack_v,
                             input logic berr_v, input logic [31:0] din,
                             input int hold, input logic poke);
        int   k;
        int   rel_at;
        logic responding;
        ob_got = 0; ob_dup = 0; ob_resp_cyc = -1; ob_as_first = -1; ob_as_last = -1;
        ob_ds_first = -1; ob_oe_first = -1; ob_oe_last = -1; ob_ready_first = -1;
        ob_rel = -1; ob_dout_bad = 0; ob_rdata = 'x; ob_err = 'x; ob_port = 'x;
        req_rw = rw; req_addr = addr; req_siz = siz; req_wdata = wdata;
        req_valid = 1'b1;
        cyc = 0;
        tick();
        req_valid = 1'b0;
        k = 0; rel_at = -1; responding = 0;
        for (int n = 0; n < 60; n++) begin
            if (cyc == 1) begin
                ob_addr_s0 = ADDR; ob_rw_s0 = RW; ob_siz_s0 = {SIZ1, SIZ0};
            end
            if (AS_n === 1'b0) begin
                if (ob_as_first < 0) ob_as_first = cyc;
                ob_as_last = cyc;
            end
            if (DS_n === 1'b0 && ob_ds_first < 0) ob_ds_first = cyc;
            if (DATA_OE === 1'b1) begin
                if (ob_oe_first < 0) ob_oe_first = cyc;
                ob_oe_last = cyc;
            end
            if (!rw && (AS_n === 1'b0 || DATA_OE === 1'b1) && DATA_OUT !== wdata) ob_dout_bad = 1;
            if (resp_valid === 1'b1) begin
                if (ob_got) ob_dup = 1;
                ob_got = 1; ob_resp_cyc = cyc;
                ob_rdata = resp_rdata; ob_err = resp_err; ob_port = resp_port;
            end
            if (cyc >= 2 && req_ready === 1'b1) begin
                ob_ready_first = cyc;
                break;
            end
            // responder behaviour for this cycle
            if (AS_n === 1'b0) begin
                if (k >= dly) begin
                    DSACK_n = dsack_v; BERR_n = berr_v; DATA_IN = din;
                    responding = 1;
                end
                k++;
            end else if (responding && rel_at < 0) begin
                rel_at = cyc + hold;
            end
            if (rel_at >= 0 && cyc >= rel_at) begin
                DSACK_n = 2'b11; BERR_n = 1'b1;
                if (ob_rel < 0) ob_rel = rel_at;
            end
            if (poke) begin
                req_valid = (rel_at >= 0 && cyc > rel_at - hold && cyc < rel_at);
                req_addr  = 28'hABCDEF0;
            end
            tick();
        end
        req_valid = 1'b0;
        DSACK_n = 2'b11; BERR_n = 1'b1;
    endtask

    task automatic test_reset();
        RST_n = 1'b1;
        #2 RST_n = 1'b0;
        #1;
        n_cmp++; if (AS_n !== 1'b1) begin n_bad++; $display("FAIL rst_as_n got %b want 1", AS_n); end
        n_cmp++; if (DS_n !== 1'b1) begin n_bad++; $display("FAIL rst_ds_n got %b want 1", DS_n); end
        n_cmp++; if (RW !== 1'b1) begin n_bad++; $display("FAIL rst_rw got %b want 1", RW); end
        n_cmp++; if (DATA_OE !== 1'b0) begin n_bad++; $display("FAIL rst_oe got %b want 0", DATA_OE); end
        n_cmp++; if (ADDR !== 28'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", ADDR); end
        n_cmp++; if (DATA_OUT !== 32'h0) begin n_bad++; $display("FAIL rst_dout got %h want 0", DATA_OUT); end
        n_cmp++; if ({SIZ1, SIZ0} !== 2'b00) begin n_bad++; $display("FAIL rst_siz got %b want 00", {SIZ1, SIZ0}); end
        n_cmp++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_port !== 2'b00) begin
            n_bad++; $display("FAIL rst_resp got v%b e%b p%b want v0 e0 p00", resp_valid, resp_err, resp_port); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", req_ready); end
        repeat (2) @(posedge CLK);
        #3 RST_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_read();
        // long read, zero-wait 32-bit responder
        sb_q.push_back('{cyc: 6, rdata: 32'hDEADBEEF, err: 1'b0, port: 2'b11});
        run_cycle(1'b1, 28'h0000100, 2'b00, 32'h0, 0, 2'b00, 1'b1, 32'hDEADBEEF, 0, 1'b0);
        exp_rdata = 32'hDEADBEEF;
        n_cmp++; if (sb_q.size() == 0) begin n_bad++; $display("FAIL rd_sb_empty got 0 want 1"); end
        else begin
            e = sb_q.pop_front();
            n_cmp++; if (ob_resp_cyc !== e.cyc) begin n_bad++; $display("FAIL rd_resp_cyc got %0d want %0d", ob_resp_cyc, e.cyc); end
            n_cmp++; if (ob_rdata !== e.rdata) begin n_bad++; $display("FAIL rd_rdata got %h want %h", ob_rdata, e.rdata); end
            n_cmp++; if (ob_err !== e.err) begin n_bad++; $display("FAIL rd_err got %b want %b", ob_err, e.err); end
            n_cmp++; if (ob_port !== e.port) begin n_bad++; $display("FAIL rd_port got %b want %b", ob_port, e.port); end
        end
        n_cmp++; if (ob_as_first !== 2 || ob_as_last !== 5) begin n_bad++; $display("FAIL rd_as_window got %0d..%0d want 2..5", ob_as_first, ob_as_last); end
        n_cmp++; if (ob_ds_first !== 2) begin n_bad++; $display("FAIL rd_ds_fall got %0d want 2", ob_ds_first); end
        n_cmp++; if (ob_oe_first !== -1) begin n_bad++; $display("FAIL rd_oe got %0d want -1 (never)", ob_oe_first); end
        n_cmp++; if (ob_addr_s0 !== 28'h0000100 || ob_rw_s0 !== 1'b1 || ob_siz_s0 !== 2'b00) begin
            n_bad++; $display("FAIL rd_s0_bus got a%h rw%b s%b want a0000100 rw1 s00", ob_addr_s0, ob_rw_s0, ob_siz_s0); end
        n_cmp++; if (ob_ready_first !== 9) begin n_bad++; $display("FAIL rd_ready got %0d want 9", ob_ready_first); end
        n_cmp++; if (ob_dup !== 1'b0) begin n_bad++; $display("FAIL rd_single_pulse got %b want 0", ob_dup); end

        // byte read, 8-bit port answering two cycles late
        sb_q.push_back('{cyc: 8, rdata: 32'h000000A5, err: 1'b0, port: 2'b01});
        run_cycle(1'b1, 28'h0000103, 2'b01, 32'h0, 2, 2'b10, 1'b1, 32'h000000A5, 0, 1'b0);
        exp_rdata = 32'h000000A5;
        e = sb_q.pop_front();
        n_cmp++; if (ob_resp_cyc !== e.cyc) begin n_bad++; $display("FAIL rdb_resp_cyc got %0d want %0d", ob_resp_cyc, e.cyc); end
        n_cmp++; if (ob_rdata !== e.rdata) begin n_bad++; $display("FAIL rdb_rdata got %h want %h", ob_rdata, e.rdata); end
        n_cmp++; if (ob_port !== e.port) begin n_bad++; $display("FAIL rdb_port got %b want %b", ob_port, e.port); end
        n_cmp++; if (ob_siz_s0 !== 2'b01) begin n_bad++; $display("FAIL rdb_siz got %b want 01", ob_siz_s0); end
        n_cmp++; if (ob_ready_first !== 11) begin n_bad++; $display("FAIL rdb_ready got %0d want 11", ob_ready_first); end
    endtask

    task automatic test_write();
        // word write, 16-bit port answering five cycles after AS_n
        sb_q.push_back('{cyc: 11, rdata: exp_rdata, err: 1'b0, port: 2'b10});
        run_cycle(1'b0, 28'h0000202, 2'b10, 32'h00001234, 5, 2'b01, 1'b1, 32'hFFFFFFFF, 0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++; if (ob_resp_cyc !== e.cyc) begin n_bad++; $display("FAIL wr_resp_cyc got %0d want %0d", ob_resp_cyc, e.cyc); end
        n_cmp++; if (ob_rdata !== e.rdata) begin n_bad++; $display("FAIL wr_rdata_hold got %h want %h", ob_rdata, e.rdata); end
        n_cmp++; if (ob_err !== e.err || ob_port !== e.port) begin
            n_bad++; $display("FAIL wr_status got e%b p%b want e%b p%b", ob_err, ob_port, e.err, e.port); end
        n_cmp++; if (ob_as_first !== 2) begin n_bad++; $display("FAIL wr_as_fall got %0d want 2", ob_as_first); end
        n_cmp++; if (ob_ds_first !== 3) begin n_bad++; $display("FAIL wr_ds_fall got %0d want 3", ob_ds_first); end
        n_cmp++; if (ob_oe_first !== 2 || ob_oe_last !== e.cyc) begin
            n_bad++; $display("FAIL wr_oe_window got %0d..%0d want 2..%0d", ob_oe_first, ob_oe_last, e.cyc); end
        n_cmp++; if (ob_rw_s0 !== 1'b0 || ob_siz_s0 !== 2'b10) begin
            n_bad++; $display("FAIL wr_s0_bus got rw%b s%b want rw0 s10", ob_rw_s0, ob_siz_s0); end
        n_cmp++; if (ob_dout_bad !== 1'b0) begin n_bad++; $display("FAIL wr_dout_stable got %b want 0", ob_dout_bad); end
        n_cmp++; if (ob_ready_first !== 14) begin n_bad++; $display("FAIL wr_ready got %0d want 14", ob_ready_first); end
        n_cmp++; if (RW !== 1'b1 || DATA_OE !== 1'b0) begin n_bad++; $display("FAIL wr_idle_bus got rw%b oe%b want rw1 oe0", RW, DATA_OE); end
    endtask

    task automatic test_berr();
        sb_q.push_back('{cyc: 6, rdata: exp_rdata, err: 1'b1, port: 2'b00});
        run_cycle(1'b1, 28'h0000400, 2'b00, 32'h0, 0, 2'b00, 1'b0, 32'hBAD0BAD0, 0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++; if (ob_resp_cyc !== e.cyc) begin n_bad++; $display("FAIL berr_resp_cyc got %0d want %0d", ob_resp_cyc, e.cyc); end
        n_cmp++; if (ob_err !== e.err) begin n_bad++; $display("FAIL berr_err got %b want %b", ob_err, e.err); end
        n_cmp++; if (ob_port !== e.port) begin n_bad++; $display("FAIL berr_port got %b want %b", ob_port, e.port); end
        n_cmp++; if (ob_rdata !== e.rdata) begin n_bad++; $display("FAIL berr_rdata got %h want %h", ob_rdata, e.rdata); end
    endtask

    task automatic test_timeout();
        // WAIT occupies cycles 4..4+TMO-1, then LATCH, then the pulse
        sb_q.push_back('{cyc: 4 + TMO + 1, rdata: exp_rdata, err: 1'b1, port: 2'b00});
        run_cycle(1'b1, 28'h0000500, 2'b00, 32'h0, 0, 2'b11, 1'b1, 32'h0, 0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++; if (ob_resp_cyc !== e.cyc) begin n_bad++; $display("FAIL tmo_resp_cyc got %0d want %0d", ob_resp_cyc, e.cyc); end
        n_cmp++; if (ob_err !== e.err || ob_port !== e.port) begin
            n_bad++; $display("FAIL tmo_status got e%b p%b want e%b p%b", ob_err, ob_port, e.err, e.port); end
        n_cmp++; if (ob_rdata !== e.rdata) begin n_bad++; $display("FAIL tmo_rdata got %h want %h", ob_rdata, e.rdata); end
        n_cmp++; if (ob_as_last !== e.cyc - 1) begin n_bad++; $display("FAIL tmo_as_neg got %0d want %0d", ob_as_last, e.cyc - 1); end
        n_cmp++; if (ob_ready_first !== e.cyc + 2) begin n_bad++; $display("FAIL tmo_ready got %0d want %0d", ob_ready_first, e.cyc + 2); end
    endtask

    task automatic test_term_hold();
        // DSACK held four cycles past S5 while the client pokes req_valid
        sb_q.push_back('{cyc: 6, rdata: 32'h55AA33CC, err: 1'b0, port: 2'b11});
        run_cycle(1'b1, 28'h0000300, 2'b00, 32'h0, 0, 2'b00, 1'b1, 32'h55AA33CC, 4, 1'b1);
        exp_rdata = 32'h55AA33CC;
        e = sb_q.pop_front();
        n_cmp++; if (ob_resp_cyc !== e.cyc || ob_rdata !== e.rdata) begin
            n_bad++; $display("FAIL hold_resp got c%0d d%h want c%0d d%h", ob_resp_cyc, ob_rdata, e.cyc, e.rdata); end
        // release in cycle 10; the two-flop synchroniser delays the view
        n_cmp++; if (ob_ready_first !== ob_rel + 3 || ob_rel !== 10) begin
            n_bad++; $display("FAIL hold_ready got %0d (rel %0d) want 13 (rel 10)", ob_ready_first, ob_rel); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (AS_n !== 1'b1 || ADDR !== 28'h0000300) begin
                n_bad++; $display("FAIL hold_no_accept got as%b a%h want as1 a0000300", AS_n, ADDR); end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_resp;
        // write with no responder, reset while in WAIT (cycle 5)
        req_rw = 1'b0; req_addr = 28'h0000600; req_siz = 2'b00; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        cyc = 0;
        tick();
        req_valid = 1'b0;
        while (cyc < 5) tick();
        n_cmp++; if (AS_n !== 1'b0 || DS_n !== 1'b0 || DATA_OE !== 1'b1) begin
            n_bad++; $display("FAIL rstm_pre got as%b ds%b oe%b want as0 ds0 oe1", AS_n, DS_n, DATA_OE); end
        #2 RST_n = 1'b0;
        #1;
        n_cmp++; if (AS_n !== 1'b1 || DS_n !== 1'b1) begin n_bad++; $display("FAIL rstm_strobes got as%b ds%b want 11", AS_n, DS_n); end
        n_cmp++; if (DATA_OE !== 1'b0 || RW !== 1'b1) begin n_bad++; $display("FAIL rstm_bus got oe%b rw%b want oe0 rw1", DATA_OE, RW); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstm_ready got %b want 1", req_ready); end
        @(posedge CLK);
        #3 RST_n = 1'b1;
        exp_rdata = 32'h0;
        saw_resp = 1'b0;
        for (int i = 0; i < TMO + 6; i++) begin
            tick();
            if (resp_valid === 1'b1) saw_resp = 1'b1;
        end
        n_cmp++; if (saw_resp !== 1'b0) begin n_bad++; $display("FAIL rstm_no_resp got %b want 0", saw_resp); end
        n_cmp++; if (req_ready !== 1'b1 || resp_rdata !== exp_rdata) begin
            n_bad++; $display("FAIL rstm_after got rdy%b d%h want rdy1 d%h", req_ready, resp_rdata, exp_rdata); end
        // the block must run a normal cycle again after reset
        sb_q.push_back('{cyc: 6, rdata: 32'h0F1E2D3C, err: 1'b0, port: 2'b11});
        run_cycle(1'b1, 28'h0000700, 2'b00, 32'h0, 0, 2'b00, 1'b1, 32'h0F1E2D3C, 0, 1'b0);
        e = sb_q.pop_front();
        n_cmp++; if (ob_resp_cyc !== e.cyc || ob_rdata !== e.rdata || ob_port !== e.port) begin
            n_bad++; $display("FAIL rstm_recover got c%0d d%h p%b want c%0d d%h p%b", ob_resp_cyc, ob_rdata, ob_port, e.cyc, e.rdata, e.port); end
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover got %0d want 0", sb_q.size()); end
    endtask

    initial begin
        req_valid = 1'b0; req_rw = 1'b1; req_addr = '0; req_siz = 2'b00; req_wdata = '0;
        DATA_IN = '0; DSACK_n = 2'b11; BERR_n = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_berr();
        test_timeout();
        test_term_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bus_initiator_030
`default_nettype wire
